// File: rtl/uart_rom_loader.sv
// uart_rom_loader
//   Boot-time bus master that loads a program image received over UART into
//   the instruction ROM. It accepts a framed byte stream and assembles the data
//   bytes into 32-bit little-endian words. Each word is written through a
//   single-outstanding valid/ready request/response handshake. The CPU is held
//   in halt while a frame is in progress.
//
//   Frame: MAGIC, LEN[7:0], LEN[15:8], LEN*4 data bytes, CSUM (XOR of data).
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   enable_i          loader may start a frame; dropping it aborts a frame
//   rx_data_i/valid_i received UART byte stream
//   rx_ready_o        byte accepted on rx_valid_i && rx_ready_o
//   mem_*             ROM write master (request and response channels)
//   halt_o, busy_o    high while a frame is in progress
//   done_o, err_o     sticky status of the last frame
//   words_o           words written in the current/last frame
module uart_rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rsp_valid_i,
  output logic        mem_rsp_ready_o,
  output logic        halt_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WR_REQ,
    WR_RSP,
    CSUM
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_q, state_n;
  logic [15:0] len_q, len_n;
  logic [31:0] word_q, word_n;
  logic [1:0]  bcnt_q, bcnt_n;
  logic [7:0]  csum_q, csum_n;
  logic [15:0] words_q, words_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  logic [15:0] len_full;
  logic [15:0] words_inc;

  assign len_full  = {rx_data_i, len_q[7:0]};
  assign words_inc = words_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      len_q   <= len_n;
      word_q  <= word_n;
      bcnt_q  <= bcnt_n;
      csum_q  <= csum_n;
      words_q <= words_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // The byte handshake is decoded per state from rx_valid_i directly, so the
  // next-state logic never depends on the rx_ready_o it drives.
  always_comb begin
    state_n         = state_q;
    len_n           = len_q;
    word_n          = word_q;
    bcnt_n          = bcnt_q;
    csum_n          = csum_q;
    words_n         = words_q;
    done_n          = done_q;
    err_n           = err_q;

    rx_ready_o      = 1'b0;
    mem_addr_o      = '0;
    mem_data_o      = '0;
    mem_sel_o       = '0;
    mem_we_o        = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        rx_ready_o = enable_i;
        if (enable_i && rx_valid_i && (rx_data_i == MAGIC)) begin
          state_n = LEN0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          words_n = '0;
          csum_n  = '0;
        end
      end

      LEN0: begin
        rx_ready_o = 1'b1;
        if (!enable_i) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (rx_valid_i) begin
          len_n   = {8'h00, rx_data_i};
          state_n = LEN1;
        end
      end

      LEN1: begin
        rx_ready_o = 1'b1;
        if (!enable_i) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (rx_valid_i) begin
          len_n = len_full;
          if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN)) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            state_n = DATA;
            bcnt_n  = '0;
          end
        end
      end

      DATA: begin
        rx_ready_o = 1'b1;
        if (!enable_i) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (rx_valid_i) begin
          // Shift right so the first byte of the group lands in bits [7:0].
          word_n = {rx_data_i, word_q[31:8]};
          csum_n = csum_q ^ rx_data_i;
          bcnt_n = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_n = WR_REQ;
          end
        end
      end

      WR_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_sel_o       = 4'hF;
        mem_addr_o      = BASE_ADDR + {14'd0, words_q, 2'b00};
        mem_data_o      = word_q;
        if (mem_req_ready_i) begin
          state_n = WR_RSP;
        end
      end

      WR_RSP: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i) begin
          words_n = words_inc;
          state_n = (words_inc == len_q) ? CSUM : DATA;
        end
      end

      CSUM: begin
        rx_ready_o = 1'b1;
        if (!enable_i) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (rx_valid_i) begin
          state_n = IDLE;
          if (rx_data_i == csum_q) begin
            done_n = 1'b1;
          end else begin
            err_n  = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Derived from the state register so both drop in the cycle IDLE is entered.
  assign halt_o  = (state_q != IDLE);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign words_o = words_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
module tb_uart_rom_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_rsp_valid_i;
  logic        mem_rsp_ready_o;
  logic        halt_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_o;

  int total = 0;
  int bad   = 0;

  // ROM slave model with programmable stall lengths.
  int          req_delay = 0;
  int          rsp_delay = 0;
  int          req_cnt   = 0;
  int          rsp_cnt   = 0;
  logic        rsp_pend  = 1'b0;
  logic [63:0] wr_log[$];

  uart_rom_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(4096),
    .MAGIC(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_i(enable_i),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_sel_o(mem_sel_o),
    .mem_we_o(mem_we_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_ready_o(mem_rsp_ready_o),
    .halt_o(halt_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .words_o(words_o)
  );

  always #5 clk = ~clk;

  assign mem_req_ready_i = mem_req_valid_o && (req_cnt >= req_delay);
  assign mem_rsp_valid_i = rsp_pend && (rsp_cnt >= rsp_delay);

  always @(posedge clk) begin
    if (rst) begin
      req_cnt  <= 0;
      rsp_cnt  <= 0;
      rsp_pend <= 1'b0;
    end else begin
      if (!mem_req_valid_o || mem_req_ready_i) req_cnt <= 0;
      else                                     req_cnt <= req_cnt + 1;
      if (mem_req_valid_o && mem_req_ready_i) begin
        rsp_pend <= 1'b1;
        rsp_cnt  <= 0;
        wr_log.push_back({mem_addr_o, mem_data_o});
      end else if (mem_rsp_valid_i && mem_rsp_ready_o) begin
        rsp_pend <= 1'b0;
      end else if (rsp_pend) begin
        rsp_cnt <= rsp_cnt + 1;
      end
    end
  end

  // Reference model: checksum and little-endian word packing.
  function automatic logic [7:0] xor_bytes(input logic [7:0] d[$]);
    logic [7:0] x = 8'h00;
    foreach (d[i]) x = x ^ d[i];
    return x;
  endfunction

  function automatic logic [31:0] pack_word(input logic [7:0] d[$], input int i);
    return {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready_o) begin
      total++; bad++;
      $display("FAIL send_byte_timeout: rx_ready_o=%b required 1 for byte %h", rx_ready_o, b);
    end
    @(posedge clk);
    #1 rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] d[$], input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (d[i]) send_byte(d[i]);
    send_byte(cs);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rx_ready_o, mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_req_valid_o,
         mem_rsp_ready_o, halt_o, busy_o, done_o, err_o, words_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got halt=%b busy=%b done=%b err=%b words=%0d req=%b required all 0",
               halt_o, busy_o, done_o, err_o, words_o, mem_req_valid_o);
    end
    rst = 1'b0;
    @(negedge clk);
    enable_i = 1'b1;
    #1;
    total++;
    if (rx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: rx_ready=%b busy=%b required 1 0", rx_ready_o, busy_o);
    end
  endtask

  task automatic test_basic(input logic bad_csum);
    logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] cs = bad_csum ? 8'h00 : xor_bytes(d);
    req_delay = 0; rsp_delay = 0;
    wr_log.delete();
    total++;
    if (halt_o !== 1'b0) begin
      bad++; $display("FAIL basic_halt_pre: halt=%b required 0", halt_o);
    end
    send_byte(8'hA5);
    total++;
    if (halt_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++; $display("FAIL basic_halt_magic: halt=%b busy=%b required 1 1", halt_o, busy_o);
    end
    send_byte(8'h02);
    send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    send_byte(cs);
    total++;
    if ({halt_o, busy_o, done_o, err_o} !== {2'b00, !bad_csum, bad_csum} || words_o !== 16'd2) begin
      bad++;
      $display("FAIL basic_status(badcs=%b): halt=%b busy=%b done=%b err=%b words=%0d required 0 0 %b %b 2",
               bad_csum, halt_o, busy_o, done_o, err_o, words_o, !bad_csum, bad_csum);
    end
    total++;
    if (wr_log.size() != 2) begin
      bad++; $display("FAIL basic_wr_count: got %0d required 2", wr_log.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (wr_log[i] !== {BASE + 32'(4 * i), pack_word(d, i)}) begin
          bad++;
          $display("FAIL basic_wr%0d: got %h required %h", i, wr_log[i], {BASE + 32'(4 * i), pack_word(d, i)});
        end
      end
    end
  endtask

  task automatic test_len_err;
    logic [15:0] lens[2] = '{16'h0000, 16'h1001};
    for (int k = 0; k < 2; k++) begin
      wr_log.delete();
      send_byte(8'hA5);
      total++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin
        bad++; $display("FAIL len_magic_clears(%0d): err=%b busy=%b required 0 1", k, err_o, busy_o);
      end
      send_byte(lens[k][7:0]);
      send_byte(lens[k][15:8]);
      total++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || halt_o !== 1'b0) begin
        bad++;
        $display("FAIL len_err(%h): err=%b busy=%b halt=%b required 1 0 0", lens[k], err_o, busy_o, halt_o);
      end
      repeat (3) @(negedge clk);
      total++;
      if (wr_log.size() != 0 || mem_req_valid_o !== 1'b0) begin
        bad++; $display("FAIL len_no_write(%h): writes=%0d required 0", lens[k], wr_log.size());
      end
    end
  endtask

  task automatic test_garbage;
    logic [7:0] junk[3] = '{8'h00, 8'hFF, 8'h5A};
    logic [7:0] d[$];
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i]);
      total++;
      if (busy_o !== 1'b0 || halt_o !== 1'b0) begin
        bad++; $display("FAIL garbage_%h: busy=%b halt=%b required 0 0", junk[i], busy_o, halt_o);
      end
    end
    for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
    wr_log.delete();
    send_frame(16'd1, d, xor_bytes(d));
    total++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || words_o !== 16'd1 || wr_log.size() != 1) begin
      bad++;
      $display("FAIL garbage_frame: done=%b err=%b words=%0d writes=%0d required 1 0 1 1",
               done_o, err_o, words_o, wr_log.size());
    end else begin
      total++;
      if (wr_log[0] !== {BASE, pack_word(d, 0)}) begin
        bad++; $display("FAIL garbage_wr: got %h required %h", wr_log[0], {BASE, pack_word(d, 0)});
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0]  d[$];
    logic [7:0]  cs;
    int          vcyc = 0, rcyc = 0, winc = 0;
    logic        captured = 1'b0;
    logic [31:0] a0 = '0, d0 = '0;
    logic [15:0] lastw;
    for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
    cs = xor_bytes(d);
    req_delay = 5; rsp_delay = 3;
    wr_log.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    lastw = words_o;
    fork
      send_byte(cs);
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (mem_req_valid_o) begin
            vcyc++;
            if (!captured) begin
              a0 = mem_addr_o; d0 = mem_data_o; captured = 1'b1;
            end else begin
              total++;
              if ({mem_addr_o, mem_data_o, mem_sel_o, mem_we_o} !== {a0, d0, 4'hF, 1'b1}) begin
                bad++;
                $display("FAIL stall_stable: addr=%h data=%h sel=%h we=%b required %h %h f 1",
                         mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, a0, d0);
              end
            end
          end
          if (mem_rsp_ready_o) rcyc++;
          if (mem_req_valid_o || mem_rsp_ready_o) begin
            total++;
            if (rx_ready_o !== 1'b0) begin
              bad++; $display("FAIL stall_rx_ready: rx_ready=%b required 0 during write", rx_ready_o);
            end
          end
          if (words_o !== lastw) begin
            winc++; lastw = words_o;
          end
        end
      end
    join
    total++;
    if (vcyc != 6 || rcyc != 4 || winc != 1) begin
      bad++;
      $display("FAIL stall_cycles: req_valid=%0d rsp_ready=%0d words_steps=%0d required 6 4 1", vcyc, rcyc, winc);
    end
    total++;
    if ({a0, d0} !== {BASE, pack_word(d, 0)} || done_o !== 1'b1 || words_o !== 16'd1 || wr_log.size() != 1) begin
      bad++;
      $display("FAIL stall_result: addr=%h data=%h done=%b words=%0d writes=%0d required %h %h 1 1 1",
               a0, d0, done_o, words_o, wr_log.size(), BASE, pack_word(d, 0));
    end
    req_delay = 0; rsp_delay = 0;
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      int          len = $urandom_range(1, 4);
      logic        good = 1'($urandom_range(0, 1));
      logic [7:0]  d[$];
      logic [7:0]  cs;
      for (int i = 0; i < 4 * len; i++) d.push_back(8'($urandom));
      cs = good ? xor_bytes(d) : (xor_bytes(d) ^ 8'($urandom_range(1, 255)));
      req_delay = $urandom_range(0, 3);
      rsp_delay = $urandom_range(0, 3);
      wr_log.delete();
      send_frame(16'(len), d, cs);
      total++;
      if ({done_o, err_o, busy_o} !== {good, !good, 1'b0} || words_o !== 16'(len)) begin
        bad++;
        $display("FAIL rand%0d_status: done=%b err=%b busy=%b words=%0d required %b %b 0 %0d",
                 f, done_o, err_o, busy_o, words_o, good, !good, len);
      end
      total++;
      if (wr_log.size() != len) begin
        bad++; $display("FAIL rand%0d_count: got %0d required %0d", f, wr_log.size(), len);
      end else begin
        for (int i = 0; i < len; i++) begin
          total++;
          if (wr_log[i] !== {BASE + 32'(4 * i), pack_word(d, i)}) begin
            bad++;
            $display("FAIL rand%0d_wr%0d: got %h required %h", f, i, wr_log[i],
                     {BASE + 32'(4 * i), pack_word(d, i)});
          end
        end
      end
    end
    req_delay = 0; rsp_delay = 0;
  endtask

  task automatic test_abort;
    wr_log.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    enable_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({busy_o, halt_o, err_o, done_o} !== 4'b0010) begin
      bad++;
      $display("FAIL abort_status: busy=%b halt=%b err=%b done=%b required 0 0 1 0", busy_o, halt_o, err_o, done_o);
    end
    repeat (3) @(negedge clk);
    total++;
    if (wr_log.size() != 0) begin
      bad++; $display("FAIL abort_no_write: writes=%0d required 0", wr_log.size());
    end
    enable_i = 1'b1;
  endtask

  task automatic test_reset_inflight;
    int n = 0;
    logic [7:0] d[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rsp_delay = 10;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    @(negedge clk);
    while (!mem_rsp_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (mem_rsp_ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_wait_rsp: rsp_ready=%b required 1", mem_rsp_ready_o);
    end
    rst = 1'b1; enable_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({rx_ready_o, mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_req_valid_o,
         mem_rsp_ready_o, halt_o, busy_o, done_o, err_o, words_o} !== '0) begin
      bad++;
      $display("FAIL rst_inflight: halt=%b busy=%b err=%b words=%0d rsp_ready=%b required all 0",
               halt_o, busy_o, err_o, words_o, mem_rsp_ready_o);
    end
    rst = 1'b0;
    rsp_delay = 0;
    @(negedge clk);
    enable_i = 1'b1;
    wr_log.delete();
    send_frame(16'd1, d, xor_bytes(d));
    total++;
    if (done_o !== 1'b1 || wr_log.size() != 1) begin
      bad++; $display("FAIL rst_recover: done=%b writes=%0d required 1 1", done_o, wr_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_len_err();
    test_garbage();
    test_stall();
    test_random();
    test_abort();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
